// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
// Holds the fetch FSM state enum, the reset PC and bubble instruction,
// and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: request/response channel between the fetch controller and the
// instruction memory. master = fetch_controller, slave = memory.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: single-entry {instr, pc} holding register used to park
// a response that arrived while decode was stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next-entry selection: load wins, clear empties, otherwise hold.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else if (clear) begin
      instr_d = 32'h0000_0000;
      pc_d    = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch against a variable-latency
// memory with one outstanding request, a one-entry skid buffer for decode
// stalls, and branch redirects that squash in-flight responses.
// Optional feature macro: FETCH_PERF_EN adds perf_instr_cnt / perf_bubble_cnt.
module fetch_controller
  import fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         StallF,
  input  logic         BranchTakenE,
  input  logic [31:0]  BranchTargetE,
  fetch_if.master      imem,
  output logic [31:0]  InstrF,
  output logic [31:0]  PCF,
  output logic [31:0]  PCPlus4F,
  output logic         InstrValidF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_instr_cnt,
  output logic [31:0]  perf_bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;

  logic         buf_load_s, buf_clear_s, buf_valid_s;
  logic [31:0]  buf_instr_s, buf_pc_s;
  logic [31:0]  br_tgt_s;

  // Redirect targets are always word aligned.
  assign br_tgt_s = BranchTargetE & 32'hFFFF_FFFC;

  fetch_skid_buffer u_skid (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .instr_in  (imem.imem_rdata),
    .pc_in     (fetch_pc_q),
    .instr_out (buf_instr_s),
    .pc_out    (buf_pc_s),
    .valid_out (buf_valid_s)
  );

  // Next state, fetch PC and decode-facing outputs; redirect outranks all.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    instr_d     = instr_q;
    pcf_d       = pcf_q;
    valid_d     = valid_q;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    case (state_q)
      BOOT: begin
        if (BranchTakenE) begin
          fetch_pc_d = br_tgt_s;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = REQ;
      end
      REQ: begin
        if (BranchTakenE) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (imem.imem_ready) begin
            fetch_pc_d = br_tgt_s;
          end else begin
            // request already on the bus: drain it before redirecting
            pend_pc_d = br_tgt_s;
            state_d   = DROP;
          end
        end else if (imem.imem_ready && !StallF) begin
          instr_d    = imem.imem_rdata;
          pcf_d      = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = pc_next(fetch_pc_q);
        end else if (imem.imem_ready) begin
          buf_load_s = 1'b1;
          fetch_pc_d = pc_next(fetch_pc_q);
          state_d    = HOLD;
        end else if (!StallF) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else begin
          valid_d = valid_q;
        end
      end
      HOLD: begin
        if (BranchTakenE) begin
          valid_d     = 1'b0;
          instr_d     = NOP_INSTR;
          buf_clear_s = 1'b1;
          fetch_pc_d  = br_tgt_s;
          state_d     = REQ;
        end else if (!StallF && buf_valid_s) begin
          instr_d     = buf_instr_s;
          pcf_d       = buf_pc_s;
          valid_d     = 1'b1;
          buf_clear_s = 1'b1;
          state_d     = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (BranchTakenE) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (imem.imem_ready) begin
            fetch_pc_d = br_tgt_s;
            state_d    = REQ;
          end else begin
            pend_pc_d = br_tgt_s;
          end
        end else if (imem.imem_ready) begin
          fetch_pc_d = pend_pc_q;
          state_d    = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    pcp4_d = pc_next(pcf_d);
    req_d  = (state_d == REQ) || (state_d == DROP);
  end

  // Architectural state and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pcf_q      <= RESET_PC;
      pcp4_q     <= pc_next(RESET_PC);
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      pcf_q      <= pcf_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc_q;
  assign InstrF         = instr_q;
  assign PCF            = pcf_q;
  assign PCPlus4F       = pcp4_q;
  assign InstrValidF    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Delivered-instruction and bubble counters; BOOT is not a bubble.
  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!StallF && valid_q) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end else if (!StallF && (state_q != BOOT)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
  end

  // Counter storage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_instr_cnt  = instr_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized stall/redirect/latency
// traffic. The reference is a program-order stream model: every instruction
// decode accepts must be the next sequential address of the current path,
// carrying the memory image word for that address.
module tb_fetch_controller;

  localparam logic [31:0] TB_NOP = 32'hE1A0_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        StallF = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = 32'd0;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        InstrValidF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_cnt, perf_bubble_cnt;
`endif

  fetch_if imem ();

  fetch_controller dut (
    .CLK           (CLK),
    .RST           (RST),
    .StallF        (StallF),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .imem          (imem),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F),
    .InstrValidF   (InstrValidF)
`ifdef FETCH_PERF_EN
    ,
    .perf_instr_cnt  (perf_instr_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  int          lat = 0;          // <0: random 0..3 wait cycles
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  logic [31:0] exp_pc = 32'd0;
  bit          br_prev = 1'b0;
  int          accepted = 0;
  int          idle = 0;
  logic        obs_valid = 1'b0;
  int          m_instr = 0;      // model perf: delivered
  int          m_bubble = 0;     // model perf: bubbles (no BOOT in measured windows)

  // Memory image: a scrambled function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One clock: check stream at the negedge, drive inputs and memory, advance.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt);
    @(negedge CLK);
    if (br_prev) chk("flush_invalid", {31'd0, InstrValidF}, 32'd0);
    if (!InstrValidF) chk("bubble_nop", InstrF, TB_NOP);
    obs_valid     = InstrValidF;
    StallF        = st;
    BranchTakenE  = br;
    BranchTargetE = tgt;
    if (!st) begin
      if (InstrValidF) m_instr++;
      else m_bubble++;
    end
    if (InstrValidF && !st) begin
      chk("stream_pcf", PCF, exp_pc);
      chk("stream_instr", InstrF, mem_fn(exp_pc));
      chk("stream_pcp4", PCPlus4F, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      accepted++;
      idle = 0;
    end else begin
      idle++;
      if (idle == 200) chk("stream_progress", 32'(idle), 32'd0);
    end
    if (br) exp_pc = tgt & 32'hFFFF_FFFC;
    br_prev = br;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    if (imem.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem.imem_addr;
        mem_cnt  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      end else begin
        chk("addr_stable", imem.imem_addr, mem_addr);
      end
      if (mem_cnt == 0) begin
        imem.imem_ready = 1'b1;
        imem.imem_rdata = mem_fn(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"}, {31'd0, imem.imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, InstrValidF}, 32'd0);
    chk({tag, "_instr"}, InstrF, TB_NOP);
    chk({tag, "_pcf"}, PCF, 32'd0);
    chk({tag, "_pcp4"}, PCPlus4F, 32'd4);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_i"}, perf_instr_cnt, 32'd0);
    chk({tag, "_perf_b"}, perf_bubble_cnt, 32'd0);
`endif
  endtask

  initial begin
    int cnt_valid;
    int acc0, mi0, mb0;
    logic [31:0] pi0, pb0;
    logic st, br;
    logic [31:0] tgt;
    pi0 = 32'd0;
    pb0 = 32'd0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'd0;

    // Reset state, then release and zero-wait streaming.
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_values("rst");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("first_req", {31'd0, imem.imem_req}, 32'd1);
    chk("first_addr", imem.imem_addr, 32'h0);
    chk("first_valid", {31'd0, InstrValidF}, 32'd0);
    lat = 0;
    cycle(1'b0, 1'b0, 32'd0);
    chk("zw_addr4", imem.imem_addr, 32'h4);
    chk("zw_valid", {31'd0, InstrValidF}, 32'd1);
    chk("zw_pcf0", PCF, 32'h0);
    cycle(1'b0, 1'b0, 32'd0);
    chk("zw_addr8", imem.imem_addr, 32'h8);
    chk("zw_pcf4", PCF, 32'h4);

    // Three-cycle memory: one instruction every third cycle.
    lat = 2;
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
`ifdef FETCH_PERF_EN
    pi0 = perf_instr_cnt;
    pb0 = perf_bubble_cnt;
`endif
    cnt_valid = 0;
    repeat (9) begin
      cycle(1'b0, 1'b0, 32'd0);
      if (obs_valid) cnt_valid++;
    end
    chk("lat3_valid_count", 32'(cnt_valid), 32'd3);
`ifdef FETCH_PERF_EN
    chk("lat3_perf_instr", perf_instr_cnt - pi0, 32'd3);
    chk("lat3_perf_bubble", perf_bubble_cnt - pb0, 32'd6);
`endif

    // Stall while the 0x10 response arrives: hold 0x0C, no request in HOLD.
    lat = 0;
    cycle(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && !(InstrValidF && PCF == 32'h0C); i++) cycle(1'b0, 1'b0, 32'd0);
    chk("stall_setup_pcf", PCF, 32'h0C);
    chk("stall_setup_addr", imem.imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      chk("hold_pcf", PCF, 32'h0C);
      chk("hold_valid", {31'd0, InstrValidF}, 32'd1);
      chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'd0);
    chk("unstall_pcf", PCF, 32'h10);
    chk("unstall_valid", {31'd0, InstrValidF}, 32'd1);
    chk("unstall_addr", imem.imem_addr, 32'h14);

    // Redirect while 0x20 is pending: drain, then request 0x100.
    lat = 4;
    cycle(1'b0, 1'b1, 32'h20);
    for (int i = 0; i < 20 && !(imem.imem_req && imem.imem_addr == 32'h20 && !mem_busy); i++)
      cycle(1'b0, 1'b0, 32'd0);
    chk("drop_setup_addr", imem.imem_addr, 32'h20);
    cycle(1'b0, 1'b1, 32'h100);
    chk("drop_addr_held", imem.imem_addr, 32'h20);
    chk("drop_req", {31'd0, imem.imem_req}, 32'd1);
    for (int i = 0; i < 10 && imem.imem_addr == 32'h20; i++) cycle(1'b0, 1'b0, 32'd0);
    chk("drop_redirect_addr", imem.imem_addr, 32'h100);

    // Two redirects while draining: the latest wins.
    cycle(1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b1, 32'h300);
    chk("drop2_addr_held", imem.imem_addr, 32'h100);
    for (int i = 0; i < 10 && imem.imem_addr == 32'h100; i++) cycle(1'b0, 1'b0, 32'd0);
    chk("drop2_redirect_addr", imem.imem_addr, 32'h300);

    // Misaligned target, then reset in the middle of a request.
    lat = 0;
    repeat (2) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h103);
    chk("align_addr", imem.imem_addr, 32'h100);
    lat = 5;
    cycle(1'b0, 1'b0, 32'd0);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_values("midreset");
    mem_busy = 1'b0;
    exp_pc   = 32'd0;
    br_prev  = 1'b0;
    @(negedge CLK);
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'hBAD0_BAD0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("late_ready_valid", {31'd0, InstrValidF}, 32'd0);
    chk("late_ready_instr", InstrF, TB_NOP);
    chk("late_ready_req", {31'd0, imem.imem_req}, 32'd1);
    chk("late_ready_addr", imem.imem_addr, 32'h0);
    chk("late_ready_pcf", PCF, 32'h0);

    // Random traffic: latency, stalls, redirects (some near the wrap point).
    lat = -1;
    acc0 = accepted;
    mi0 = m_instr;
    mb0 = m_bubble;
`ifdef FETCH_PERF_EN
    pi0 = perf_instr_cnt;
    pb0 = perf_bubble_cnt;
`endif
    for (int i = 0; i < 1500; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(st, br, tgt);
    end
    chk("random_progress", {31'd0, (accepted - acc0) > 200}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("random_perf_instr", perf_instr_cnt - pi0, 32'(m_instr - mi0));
    chk("random_perf_bubble", perf_bubble_cnt - pb0, 32'(m_bubble - mb0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch between the program counter and a variable-latency instruction memory. Holds one outstanding request, absorbs decode stalls in a single-entry skid buffer, and applies branch redirects from execute. Drops any response that belongs to a squashed path. It replaces direct PC-to-memory wiring at the front of the 5-stage pipeline and presents registered InstrF / PCF / PCPlus4F to the decode pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'hE1A0_0000, value of InstrF while invalid (ARM MOV r0,r0)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- StallF  in  1  decode cannot accept; hold outputs
- BranchTakenE  in  1  redirect pulse from execute
- BranchTargetE  in  32  redirect address; bits [1:0] forced to 0
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_ready  in  1  response valid this cycle; completes the request
- imem_rdata  in  32  response instruction
- InstrF  out  32  instruction to decode
- PCF  out  32  address of InstrF
- PCPlus4F  out  32  PCF + 4, modulo 2^32
- InstrValidF  out  1  InstrF is a real instruction

## Operation
- States: BOOT, REQ, HOLD, DROP.
- Internal registers:
  - fetch_pc: address of the current or next request.
  - pend_pc: redirect target held while draining.
  - buf_instr, buf_pc: skid buffer.
- BOOT: imem_req=0, and imem_ready is ignored. Moves to REQ in the first cycle after reset release.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - imem_ready & !StallF: load InstrF/PCF from rdata/fetch_pc, set InstrValidF=1, fetch_pc+=4, stay in REQ.
  - imem_ready & StallF: load the buffer from rdata/fetch_pc, fetch_pc+=4, go to HOLD. Outputs hold.
  - !imem_ready & !StallF: InstrValidF=0 (bubble). InstrF=NOP_INSTR.
  - !imem_ready & StallF: outputs hold.
- HOLD: imem_req=0. When !StallF, outputs load from the buffer, InstrValidF=1, go to REQ.
- Redirect (BranchTakenE=1) has priority over everything except reset:
  - InstrValidF=0 and InstrF=NOP_INSTR next cycle, even if StallF=1 (flush overrides stall).
  - REQ with imem_ready=1: discard the response, fetch_pc=target, stay in REQ.
  - REQ with imem_ready=0: the request cannot be withdrawn. Set pend_pc=target and go to DROP.
  - HOLD: discard the buffer, fetch_pc=target, go to REQ.
  - DROP: pend_pc=target (the latest redirect wins).
- DROP: imem_req=1, imem_addr=old fetch_pc, held stable. On imem_ready, discard the response, set fetch_pc=pend_pc, go to REQ.
- Handshake rule: once imem_req=1, imem_addr stays stable until the cycle imem_ready=1. imem_ready with imem_req=0 is ignored.
- fetch_pc wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset values:
  - State BOOT.
  - fetch_pc = PCF = RESET_PC.
  - PCPlus4F = RESET_PC+4.
  - InstrF = NOP_INSTR.
  - InstrValidF = 0, imem_req = 0.
  - Buffer cleared.
- The first request is issued in the first cycle after reset release. The first InstrValidF comes one cycle after the first imem_ready.
- Zero-wait memory (imem_ready in the same cycle as imem_req) sustains 1 instruction per cycle.
- Redirect to first target request on imem_addr:
  - 1 cycle from REQ or HOLD.
  - From DROP: the cycle after the draining imem_ready.
- imem_req and imem_addr are functions of state and registers only. There is no combinational path from StallF, BranchTakenE or imem_ready to any output.
- Reset mid-request abandons the transaction. The memory shares RST and must abandon it too.

## Configuration
- FETCH_PERF_EN defined: adds two 32-bit outputs.
  - perf_instr_cnt: counts cycles with InstrValidF=1 & !StallF.
  - perf_bubble_cnt: counts cycles with InstrValidF=0 & !StallF, excluding BOOT.
  - Both reset to 0 and wrap modulo 2^32.
- FETCH_PERF_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package fetch_pkg holds:
  - The state enum (BOOT/REQ/HOLD/DROP).
  - The RESET_PC and NOP_INSTR defaults.
  - The PC increment constant 32'd4.
- One sub-module, fetch_skid_buffer: single-entry {instr, pc} holding register with load, clear and valid flag.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory → imem_addr 0,4,8 on consecutive cycles. InstrValidF=1 from cycle 2, with PCF 0,4,8.
- 3-cycle memory latency → InstrValidF pattern 0,0,1 repeating. perf_bubble_cnt=2 per instruction with FETCH_PERF_EN.
- StallF high for 4 cycles while the response at 0x10 arrives → outputs hold at PCF=0x0C. imem_req=0 in HOLD. 0x10 appears the cycle after StallF falls. No loss or duplication.
- BranchTakenE with target 0x100 while a 0x20 request is pending → imem_addr held at 0x20 until ready. The 0x20 response is discarded, then imem_addr=0x100. PCF 0x20 never shows valid.
- Two redirects in DROP (0x200, then 0x300) → the next request is to 0x300.
- Target 0x103, and RST asserted mid-request → fetch address 0x100. After reset, state BOOT, outputs at reset values, and a late imem_ready is ignored.
